// File: rtl/irq_trap_sequencer.sv
// rtl/irq_trap_sequencer.sv - machine-mode interrupt/trap and mret sequencer
// Synchronises irq lines, takes traps at execute boundaries and drives CSR writes and PC redirect.
module irq_trap_sequencer #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            timer_irq,
  input  logic            ext_irq,
  input  logic            mie_mtie,
  input  logic            mie_meie,
  input  logic            inst_valid,
  input  logic            is_mret,
  input  logic [XLEN-1:0] pc_exe,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            mstatus_wr_en,
  input  logic            mstatus_wr_mie,
  input  logic            mstatus_wr_mpie,
  output logic            mstatus_mie,
  output logic            mstatus_mpie,
  output logic            epc_wr_en,
  output logic [XLEN-1:0] epc_wr_data,
  output logic            cause_wr_en,
  output logic [XLEN-1:0] cause_wr_data,
  output logic            flush,
  output logic            stall,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_TRAP_SAVE = 2'd1;
  localparam logic [1:0] ST_TRAP_JUMP = 2'd2;
  localparam logic [1:0] ST_MRET_JUMP = 2'd3;

  localparam logic [3:0] CODE_EXT = 4'd11;
  localparam logic [3:0] CODE_TMR = 4'd7;

  logic [1:0]             state_q, state_d;
  logic                   mie_q, mie_d;
  logic                   mpie_q, mpie_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [3:0]             code_q, code_d;
  logic [SYNC_STAGES-1:0] tmr_sync_q, tmr_sync_d;
  logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;

  logic            pend_ext;
  logic            pend_tmr;
  logic            take;
  logic [XLEN-1:0] tvec_base;

  always_comb begin
    tmr_sync_d    = tmr_sync_q;
    ext_sync_d    = ext_sync_q;
    tmr_sync_d[0] = timer_irq;
    ext_sync_d[0] = ext_irq;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      tmr_sync_d[i] = tmr_sync_q[i-1];
      ext_sync_d[i] = ext_sync_q[i-1];
    end
  end

  assign pend_ext = ext_sync_q[SYNC_STAGES-1] & mie_meie;
  assign pend_tmr = tmr_sync_q[SYNC_STAGES-1] & mie_mtie;
  assign take     = mie_q & (pend_ext | pend_tmr) & inst_valid & ~is_mret;

  always_comb begin
    state_d = state_q;
    mie_d   = mie_q;
    mpie_d  = mpie_q;
    pc_d    = pc_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        // mret wins over a pending interrupt; CSR writes lose to either
        if (inst_valid && is_mret) begin
          state_d = ST_MRET_JUMP;
        end else if (take) begin
          state_d = ST_TRAP_SAVE;
          pc_d    = pc_exe;
          code_d  = pend_ext ? CODE_EXT : CODE_TMR;
        end else if (mstatus_wr_en) begin
          mie_d  = mstatus_wr_mie;
          mpie_d = mstatus_wr_mpie;
        end
      end
      ST_TRAP_SAVE: begin
        mpie_d  = mie_q;
        mie_d   = 1'b0;
        state_d = ST_TRAP_JUMP;
      end
      ST_TRAP_JUMP: begin
        state_d = ST_IDLE;
      end
      ST_MRET_JUMP: begin
        mie_d   = mpie_q;
        mpie_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      pc_q       <= '0;
      code_q     <= '0;
      tmr_sync_q <= '0;
      ext_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      pc_q       <= pc_d;
      code_q     <= code_d;
      tmr_sync_q <= tmr_sync_d;
      ext_sync_q <= ext_sync_d;
    end
  end

  assign tvec_base = {mtvec[XLEN-1:2], 2'b00};

  // Outputs depend only on the registered state, so reset clears them immediately
  always_comb begin
    epc_wr_en     = 1'b0;
    epc_wr_data   = '0;
    cause_wr_en   = 1'b0;
    cause_wr_data = '0;
    flush         = 1'b0;
    stall         = 1'b0;
    pc_redirect   = 1'b0;
    pc_target     = '0;
    case (state_q)
      ST_TRAP_SAVE: begin
        epc_wr_en     = 1'b1;
        epc_wr_data   = pc_q;
        cause_wr_en   = 1'b1;
        cause_wr_data = {1'b1, {(XLEN-5){1'b0}}, code_q};
        stall         = 1'b1;
        flush         = 1'b1;
      end
      ST_TRAP_JUMP: begin
        pc_redirect = 1'b1;
        flush       = 1'b1;
        if (mtvec[1:0] == 2'b01) begin
          pc_target = tvec_base + {{(XLEN-6){1'b0}}, code_q, 2'b00};
        end else begin
          pc_target = tvec_base;
        end
      end
      ST_MRET_JUMP: begin
        pc_redirect = 1'b1;
        flush       = 1'b1;
        pc_target   = {mepc[XLEN-1:2], 2'b00};
      end
      default: begin
        pc_target = '0;
      end
    endcase
  end

  assign mstatus_mie  = mie_q;
  assign mstatus_mpie = mpie_q;

endmodule
